// File: rtl/axilite_arbiter_if.sv
// AXI-lite bus bundle shared by the arbiter's two slave ports and its master port.
// Signal names follow AXI-lite so the bridge side reads naturally.
interface axilite_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   AWADDR;
    logic [2:0]      AWPROT;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic [2:0]      ARPROT;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARPROT, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RVALID,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARPROT, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axilite_arbiter.sv
// Two-master to one-slave AXI-lite arbiter with independent round-robin
// write and read grants, held until the owner's outstanding traffic drains.
module axilite_arbiter #(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int LGMAXOUTSTANDING = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    axilite_arbiter_if.slave  S0_AXI,
    axilite_arbiter_if.slave  S1_AXI,
    axilite_arbiter_if.master M_AXI
);
    localparam logic [2:0] W_IDLE   = 3'd0;
    localparam logic [2:0] W_GNT0   = 3'd1;
    localparam logic [2:0] W_GNT1   = 3'd2;
    localparam logic [2:0] W_DRAIN0 = 3'd3;
    localparam logic [2:0] W_DRAIN1 = 3'd4;
    localparam logic [2:0] R_IDLE   = 3'd0;
    localparam logic [2:0] R_GNT0   = 3'd1;
    localparam logic [2:0] R_GNT1   = 3'd2;
    localparam logic [2:0] R_DRAIN0 = 3'd3;
    localparam logic [2:0] R_DRAIN1 = 3'd4;
    localparam logic [LGMAXOUTSTANDING-1:0] C_MAX = '1;

    logic [2:0] r_wstate, r_rstate, w_wnext, w_rnext;
    logic       r_wlast, r_rlast, w_wlast_nx, w_rlast_nx;
    logic [LGMAXOUTSTANDING-1:0] r_awcnt, r_wcnt, r_arcnt;

    logic w_run;
    logic w_wown1, w_wact, w_wgnt, w_wdrain;
    logic w_sel_awvalid, w_sel_wvalid, w_sel_bready;
    logic w_aw_ok, w_w_ok, w_b_ok;
    logic w_aw_hs, w_w_hs, w_b_hs;
    logic w_wreq0, w_wreq1, w_wreq_oth, w_wzero;
    logic w_rown1, w_ract, w_rgnt, w_rdrain;
    logic w_sel_arvalid, w_sel_rready;
    logic w_ar_ok, w_r_ok, w_ar_hs, w_r_hs, w_rreq_oth;
    logic [C_AXI_ADDR_WIDTH-1:0]   w_awaddr, w_araddr;
    logic [C_AXI_DATA_WIDTH-1:0]   w_wdata;
    logic [C_AXI_DATA_WIDTH/8-1:0] w_wstrb;

    // every handshake output is forced low while reset is held
    assign w_run = !ARESET;

    // write-side ownership and gating
    assign w_wown1  = (r_wstate == W_GNT1) || (r_wstate == W_DRAIN1);
    assign w_wact   = (r_wstate != W_IDLE);
    assign w_wgnt   = (r_wstate == W_GNT0) || (r_wstate == W_GNT1);
    assign w_wdrain = (r_wstate == W_DRAIN0) || (r_wstate == W_DRAIN1);
    assign w_sel_awvalid = w_wown1 ? S1_AXI.AWVALID : S0_AXI.AWVALID;
    assign w_sel_wvalid  = w_wown1 ? S1_AXI.WVALID  : S0_AXI.WVALID;
    assign w_sel_bready  = w_wown1 ? S1_AXI.BREADY  : S0_AXI.BREADY;
    // while draining, only the half of a write that is still owed may pass
    assign w_aw_ok = w_run && ((w_wgnt && r_awcnt != C_MAX)
                   || (w_wdrain && r_awcnt < r_wcnt));
    assign w_w_ok  = w_run && ((w_wgnt && r_wcnt != C_MAX)
                   || (w_wdrain && r_wcnt < r_awcnt));
    assign w_b_ok  = w_run && w_wact;
    assign w_aw_hs = w_aw_ok && w_sel_awvalid && M_AXI.AWREADY;
    assign w_w_hs  = w_w_ok && w_sel_wvalid && M_AXI.WREADY;
    assign w_b_hs  = w_b_ok && w_sel_bready && M_AXI.BVALID;
    assign w_wreq0 = S0_AXI.AWVALID || S0_AXI.WVALID;
    assign w_wreq1 = S1_AXI.AWVALID || S1_AXI.WVALID;
    assign w_wreq_oth = w_wown1 ? w_wreq0 : w_wreq1;
    assign w_wzero = (r_awcnt == '0) && (r_wcnt == '0);

    assign w_awaddr = w_wown1 ? S1_AXI.AWADDR : S0_AXI.AWADDR;
    assign w_wdata  = w_wown1 ? S1_AXI.WDATA  : S0_AXI.WDATA;
    assign w_wstrb  = w_wown1 ? S1_AXI.WSTRB  : S0_AXI.WSTRB;
    assign M_AXI.AWADDR  = w_awaddr;
    assign M_AXI.AWPROT  = w_wown1 ? S1_AXI.AWPROT : S0_AXI.AWPROT;
    assign M_AXI.AWVALID = w_aw_ok && w_sel_awvalid;
    assign M_AXI.WDATA   = w_wdata;
    assign M_AXI.WSTRB   = w_wstrb;
    assign M_AXI.WVALID  = w_w_ok && w_sel_wvalid;
    assign M_AXI.BREADY  = w_b_ok && w_sel_bready;
    assign S0_AXI.AWREADY = w_aw_ok && !w_wown1 && M_AXI.AWREADY;
    assign S1_AXI.AWREADY = w_aw_ok && w_wown1 && M_AXI.AWREADY;
    assign S0_AXI.WREADY  = w_w_ok && !w_wown1 && M_AXI.WREADY;
    assign S1_AXI.WREADY  = w_w_ok && w_wown1 && M_AXI.WREADY;
    assign S0_AXI.BVALID  = w_b_ok && !w_wown1 && M_AXI.BVALID;
    assign S1_AXI.BVALID  = w_b_ok && w_wown1 && M_AXI.BVALID;
    assign S0_AXI.BRESP   = M_AXI.BRESP;
    assign S1_AXI.BRESP   = M_AXI.BRESP;

    // read-side ownership and gating
    assign w_rown1  = (r_rstate == R_GNT1) || (r_rstate == R_DRAIN1);
    assign w_ract   = (r_rstate != R_IDLE);
    assign w_rgnt   = (r_rstate == R_GNT0) || (r_rstate == R_GNT1);
    assign w_rdrain = (r_rstate == R_DRAIN0) || (r_rstate == R_DRAIN1);
    assign w_sel_arvalid = w_rown1 ? S1_AXI.ARVALID : S0_AXI.ARVALID;
    assign w_sel_rready  = w_rown1 ? S1_AXI.RREADY  : S0_AXI.RREADY;
    assign w_ar_ok = w_run && w_rgnt && (r_arcnt != C_MAX);
    assign w_r_ok  = w_run && w_ract;
    assign w_ar_hs = w_ar_ok && w_sel_arvalid && M_AXI.ARREADY;
    assign w_r_hs  = w_r_ok && w_sel_rready && M_AXI.RVALID;
    assign w_rreq_oth = w_rown1 ? S0_AXI.ARVALID : S1_AXI.ARVALID;

    assign w_araddr = w_rown1 ? S1_AXI.ARADDR : S0_AXI.ARADDR;
    assign M_AXI.ARADDR  = w_araddr;
    assign M_AXI.ARPROT  = w_rown1 ? S1_AXI.ARPROT : S0_AXI.ARPROT;
    assign M_AXI.ARVALID = w_ar_ok && w_sel_arvalid;
    assign M_AXI.RREADY  = w_r_ok && w_sel_rready;
    assign S0_AXI.ARREADY = w_ar_ok && !w_rown1 && M_AXI.ARREADY;
    assign S1_AXI.ARREADY = w_ar_ok && w_rown1 && M_AXI.ARREADY;
    assign S0_AXI.RVALID  = w_r_ok && !w_rown1 && M_AXI.RVALID;
    assign S1_AXI.RVALID  = w_r_ok && w_rown1 && M_AXI.RVALID;
    assign S0_AXI.RDATA   = M_AXI.RDATA;
    assign S1_AXI.RDATA   = M_AXI.RDATA;
    assign S0_AXI.RRESP   = M_AXI.RRESP;
    assign S1_AXI.RRESP   = M_AXI.RRESP;

    // write grant: round-robin from idle, drain before handing over
    always_comb begin
        w_wnext    = r_wstate;
        w_wlast_nx = r_wlast;
        case (r_wstate)
            W_IDLE: begin
                if (w_wreq0 && (!w_wreq1 || r_wlast)) begin
                    w_wnext    = W_GNT0;
                    w_wlast_nx = 1'b0;
                end else if (w_wreq1) begin
                    w_wnext    = W_GNT1;
                    w_wlast_nx = 1'b1;
                end
            end
            W_GNT0, W_GNT1: begin
                if (w_wreq_oth)
                    w_wnext = w_wown1 ? W_DRAIN1 : W_DRAIN0;
                else if (w_wzero && !w_sel_awvalid && !w_sel_wvalid && !w_b_hs)
                    w_wnext = W_IDLE;
            end
            W_DRAIN0: begin
                if (w_wzero && !w_b_hs) begin
                    w_wnext    = W_GNT1;
                    w_wlast_nx = 1'b1;
                end
            end
            W_DRAIN1: begin
                if (w_wzero && !w_b_hs) begin
                    w_wnext    = W_GNT0;
                    w_wlast_nx = 1'b0;
                end
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    // read grant: same policy as the write side, keyed on ARVALID
    always_comb begin
        w_rnext    = r_rstate;
        w_rlast_nx = r_rlast;
        case (r_rstate)
            R_IDLE: begin
                if (S0_AXI.ARVALID && (!S1_AXI.ARVALID || r_rlast)) begin
                    w_rnext    = R_GNT0;
                    w_rlast_nx = 1'b0;
                end else if (S1_AXI.ARVALID) begin
                    w_rnext    = R_GNT1;
                    w_rlast_nx = 1'b1;
                end
            end
            R_GNT0, R_GNT1: begin
                if (w_rreq_oth)
                    w_rnext = w_rown1 ? R_DRAIN1 : R_DRAIN0;
                else if (r_arcnt == '0 && !w_sel_arvalid && !w_r_hs)
                    w_rnext = R_IDLE;
            end
            R_DRAIN0: begin
                if (r_arcnt == '0 && !w_r_hs) begin
                    w_rnext    = R_GNT1;
                    w_rlast_nx = 1'b1;
                end
            end
            R_DRAIN1: begin
                if (r_arcnt == '0 && !w_r_hs) begin
                    w_rnext    = R_GNT0;
                    w_rlast_nx = 1'b0;
                end
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    // grant state, last winner and outstanding counters
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_wlast  <= 1'b1;
            r_rlast  <= 1'b1;
            r_awcnt  <= '0;
            r_wcnt   <= '0;
            r_arcnt  <= '0;
        end else begin
            r_wstate <= w_wnext;
            r_rstate <= w_rnext;
            r_wlast  <= w_wlast_nx;
            r_rlast  <= w_rlast_nx;
            r_awcnt  <= r_awcnt + LGMAXOUTSTANDING'(w_aw_hs)
                                - LGMAXOUTSTANDING'(w_b_hs);
            r_wcnt   <= r_wcnt + LGMAXOUTSTANDING'(w_w_hs)
                               - LGMAXOUTSTANDING'(w_b_hs);
            r_arcnt  <= r_arcnt + LGMAXOUTSTANDING'(w_ar_hs)
                                - LGMAXOUTSTANDING'(w_r_hs);
        end
    end
endmodule
